// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them
// out as start / data / optional parity / stop bits on the 16x baud enable.
module uart_tx_serializer #(
  parameter int RD_LATENCY = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BAUD16_EN,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic       STOP2,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_DO,
  output logic       FIFO_RDB,
  output logic       TX,
  output logic       TX_BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAT_LAST  = 3'(RD_LATENCY);

  state_t     state_q;
  logic [3:0] tick_q;
  logic [2:0] lat_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       bit8_q;
  logic       par_en_q;
  logic       stop2_q;
  logic       par_q;
  logic       tx_q;
  logic       rdb_q;
  logic       busy_q;
  logic       done_q;

  logic       in_bit;
  logic       bit_end;
  logic       data_last;
  logic [7:0] cap_data;
  logic       cap_par;

  assign in_bit = (state_q == S_START) || (state_q == S_DATA) ||
                  (state_q == S_PARITY) || (state_q == S_STOP);

  assign bit_end   = in_bit && BAUD16_EN && (tick_q == TICK_LAST);
  assign data_last = (bit_q == (bit8_q ? 3'd7 : 3'd6));

  // In 7-bit mode bit 7 is masked so it is neither sent nor counted in parity.
  assign cap_data = BIT8 ? FIFO_DO : {1'b0, FIFO_DO[6:0]};
  assign cap_par  = (^cap_data) ^ ODD_N_EVEN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      tick_q   <= 4'd0;
      lat_q    <= 3'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rdb_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rdb_q  <= 1'b1;

      if (in_bit && BAUD16_EN) begin
        tick_q <= bit_end ? 4'd0 : tick_q + 4'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (!FIFO_EMPTY) begin
            rdb_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end

        S_READ: begin
          lat_q   <= 3'd1;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            shift_q  <= cap_data;
            par_q    <= cap_par;
            bit8_q   <= BIT8;
            par_en_q <= PARITY_EN;
            stop2_q  <= STOP2;
            lat_q    <= 3'd0;
            tick_q   <= 4'd0;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= 3'd0;
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (data_last) begin
              bit_q <= 3'd0;
              if (par_en_q) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (stop2_q && (bit_q == 3'd0)) begin
              bit_q <= 3'd1;
            end else begin
              bit_q   <= 3'd0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FIFO_RDB   = rdb_q;
  assign TX         = tx_q;
  assign TX_BUSY    = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a 2-clock-latency FIFO model
// and a tick-counting frame monitor.
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BAUD16_EN;
  logic       BIT8;
  logic       PARITY_EN;
  logic       ODD_N_EVEN;
  logic       STOP2;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_DO = 8'h00;
  logic       FIFO_RDB;
  logic       TX;
  logic       TX_BUSY;
  logic       FRAME_DONE;

  int n_vec = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_done = 0;
  int n_rd_bad = 0;
  bit in_frame = 1'b0;

  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] stage1 = 8'h00;

  uart_tx_serializer #(
    .RD_LATENCY(2),
    .OVERSAMPLE(16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BAUD16_EN (BAUD16_EN),
    .BIT8      (BIT8),
    .PARITY_EN (PARITY_EN),
    .ODD_N_EVEN(ODD_N_EVEN),
    .STOP2     (STOP2),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DO   (FIFO_DO),
    .FIFO_RDB  (FIFO_RDB),
    .TX        (TX),
    .TX_BUSY   (TX_BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  assign FIFO_EMPTY = (wr_ptr == rd_ptr);

  // FIFO model: core stage then output register, so data is valid two
  // edges after the edge that samples FIFO_RDB low.
  always @(posedge CLK) begin
    if (!FIFO_RDB) begin
      n_rd <= n_rd + 1;
      if (FIFO_EMPTY || in_frame) n_rd_bad <= n_rd_bad + 1;
    end
    if (FRAME_DONE) n_done <= n_done + 1;
    if (!FIFO_RDB && !FIFO_EMPTY) begin
      stage1 <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
    FIFO_DO <= stage1;
  end

  // One baud tick every 4 clocks -> 64 clocks per bit.
  initial begin
    BAUD16_EN = 1'b0;
    forever begin
      repeat (3) @(negedge CLK);
      BAUD16_EN = 1'b1;
      @(negedge CLK);
      BAUD16_EN = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  // Collects nb bit values (first bit in the MSB side of the result) and
  // requires every bit to last exactly 16 sampled ticks.
  task automatic get_frame(input int nb, output logic [15:0] seq,
                           output bit ok);
    int   cyc;
    int   ticks;
    logic cur;
    ok  = 1'b1;
    seq = 16'h0;
    cyc = 0;
    while (TX !== 1'b0 && cyc < 3000) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    if (TX !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    in_frame = 1'b1;
    if (TX_BUSY !== 1'b1) ok = 1'b0;
    for (int i = 0; i < nb; i++) begin
      cur   = TX;
      seq   = {seq[14:0], cur};
      ticks = 0;
      cyc   = 0;
      while (ticks < 16 && cyc < 200) begin
        @(posedge CLK);
        #1;
        cyc++;
        if (BAUD16_EN) ticks++;
        if (ticks < 16 && (TX !== cur || FRAME_DONE !== 1'b0)) ok = 1'b0;
      end
      if (ticks < 16) ok = 1'b0;
    end
    if (FRAME_DONE !== 1'b1 || TX_BUSY !== 1'b0 || TX !== 1'b1) ok = 1'b0;
    in_frame = 1'b0;
  endtask

  initial begin
    logic [15:0] seq;
    bit          ok;
    bit          quiet;
    int          r0;
    int          d0;
    int          cyc;

    RESET      = 1'b1;
    BIT8       = 1'b1;
    PARITY_EN  = 1'b0;
    ODD_N_EVEN = 1'b0;
    STOP2      = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(TX), 1);
    check("rst_rdb", 32'(FIFO_RDB), 1);
    check("rst_busy", 32'(TX_BUSY), 0);
    check("rst_done", 32'(FRAME_DONE), 0);
    RESET = 1'b0;

    // 8N1, 0x55
    r0 = n_rd;
    d0 = n_done;
    push(8'h55);
    get_frame(10, seq, ok);
    check("8n1_bits", 32'(seq), 32'b0101010101);
    check("8n1_timing", 32'(ok), 1);
    repeat (5) @(negedge CLK);
    check("8n1_reads", n_rd - r0, 1);
    check("8n1_done", n_done - d0, 1);
    check("8n1_busy_after", 32'(TX_BUSY), 0);

    // 8E1 / 8O1, 0x41
    PARITY_EN = 1'b1;
    push(8'h41);
    get_frame(11, seq, ok);
    check("8e1_bits", 32'(seq), 32'b01000001001);
    check("8e1_timing", 32'(ok), 1);
    ODD_N_EVEN = 1'b1;
    push(8'h41);
    get_frame(11, seq, ok);
    check("8o1_bits", 32'(seq), 32'b01000001011);
    check("8o1_timing", 32'(ok), 1);

    // 7N2, 0xC1; config is changed mid-frame and must not disturb it
    @(negedge CLK);
    BIT8       = 1'b0;
    PARITY_EN  = 1'b0;
    ODD_N_EVEN = 1'b0;
    STOP2      = 1'b1;
    d0 = n_done;
    push(8'hC1);
    fork
      get_frame(10, seq, ok);
      begin
        repeat (60) @(negedge CLK);
        BIT8      = 1'b1;
        PARITY_EN = 1'b1;
        STOP2     = 1'b0;
      end
    join
    check("7n2_bits", 32'(seq), 32'b0100000111);
    check("7n2_timing", 32'(ok), 1);
    check("7n2_done", n_done - d0, 1);
    PARITY_EN = 1'b0;

    // empty FIFO stays quiet
    quiet = 1'b1;
    r0 = n_rd;
    repeat (1000) begin
      @(negedge CLK);
      if (TX !== 1'b1 || FIFO_RDB !== 1'b1 || TX_BUSY !== 1'b0) quiet = 1'b0;
    end
    check("empty_quiet", 32'(quiet), 1);
    check("empty_reads", n_rd - r0, 0);

    // three back-to-back bytes
    r0 = n_rd;
    d0 = n_done;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    get_frame(10, seq, ok);
    check("b2b_0_bits", 32'(seq), 32'b0100000001);
    check("b2b_0_timing", 32'(ok), 1);
    get_frame(10, seq, ok);
    check("b2b_1_bits", 32'(seq), 32'b0010000001);
    check("b2b_1_timing", 32'(ok), 1);
    get_frame(10, seq, ok);
    check("b2b_2_bits", 32'(seq), 32'b0110000001);
    check("b2b_2_timing", 32'(ok), 1);
    repeat (10) @(negedge CLK);
    check("b2b_reads", n_rd - r0, 3);
    check("b2b_done", n_done - d0, 3);
    check("bad_reads", n_rd_bad, 0);

    // reset during data bit 3 of a 0x00 frame
    push(8'h00);
    cyc = 0;
    while (TX !== 1'b0 && cyc < 3000) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check("rst_mid_start", 32'(TX), 0);
    repeat (286) @(posedge CLK);
    #1;
    check("rst_mid_pre_tx", 32'(TX), 0);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_mid_tx", 32'(TX), 1);
    check("rst_mid_rdb", 32'(FIFO_RDB), 1);
    check("rst_mid_busy", 32'(TX_BUSY), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    r0 = n_rd;
    push(8'hA5);
    get_frame(10, seq, ok);
    check("post_rst_bits", 32'(seq), 32'b0101001011);
    check("post_rst_timing", 32'(ok), 1);
    repeat (5) @(negedge CLK);
    check("post_rst_reads", n_rd - r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
